// File: rtl/img_proc_pkg.sv
// Shared widths, default frame geometry, frame FSM states and the
// sum-to-pixel conversion used by the image result packer.
package img_proc_pkg;

  localparam int PIXEL_W        = 8;
  localparam int SUM_W          = 16;
  localparam int DEF_OUT_WIDTH  = 511;
  localparam int DEF_OUT_HEIGHT = 511;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } frame_state_t;

  // Arithmetic right shift, then clamp into the unsigned 8-bit pixel range.
  function automatic logic [PIXEL_W-1:0] saturate_pixel(
    input logic signed [SUM_W-1:0] sum,
    input int unsigned             shift
  );
    logic signed [SUM_W-1:0] s;
    s = sum >>> shift;
    if (s[SUM_W-1]) begin
      return '0;
    end else if (|s[SUM_W-2:PIXEL_W]) begin
      return '1;
    end else begin
      return s[PIXEL_W-1:0];
    end
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous show-ahead FIFO: rd_data always presents the head entry.
// A write while full is accepted only when a read frees a slot the same cycle.
module result_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_wr && !clear) mem[wr_ptr] <= wr_data;
  end

  // Pointers and fill level; clear has priority over any access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/image_result_packer.sv
// Converts convolution sums to saturated pixels, buffers them and emits them
// downstream with line/frame markers and a frame-complete pulse.
//
// Output handshake: a pixel moves on a rising edge where pixel_out_valid and
// pixel_out_ready are both high. While valid is high and ready is low,
// pixel_out/eol/eof are held. Valid never depends on ready. The input side
// has no backpressure; pause_upstream is advisory and full-FIFO inputs drop.
module image_result_packer
  import img_proc_pkg::*;
#(
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int OUT_HEIGHT = DEF_OUT_HEIGHT,
  parameter int SHIFT      = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_LEVEL   = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SUM_W-1:0]   processed_data_in,
  input  logic               processed_data_valid,
  input  logic               soft_clear,
  output logic [PIXEL_W-1:0] pixel_out,
  output logic               pixel_out_valid,
  input  logic               pixel_out_ready,
  output logic               eol,
  output logic               eof,
  output logic               pause_upstream,
  output logic               overflow,
  output logic               frame_done,
  output frame_state_t       state_dbg
);

  localparam int CW = (OUT_WIDTH  > 1) ? $clog2(OUT_WIDTH)  : 1;
  localparam int RW = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [PIXEL_W-1:0] fifo_dout;
  logic [AW:0]        fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               wr_en;
  logic               rd_en;
  logic               last_col;
  logic               last_row;
  logic [CW-1:0]      col_q;
  logic [RW-1:0]      row_q;
  frame_state_t       state_q;
  frame_state_t       state_d;

  assign wr_en = processed_data_valid && !soft_clear;
  assign rd_en = pixel_out_valid && pixel_out_ready && !soft_clear;

  result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIXEL_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (soft_clear),
    .wr_en   (wr_en),
    .wr_data (saturate_pixel(processed_data_in, SHIFT)),
    .rd_en   (rd_en),
    .rd_data (fifo_dout),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign last_col        = (col_q == CW'(OUT_WIDTH - 1));
  assign last_row        = (row_q == RW'(OUT_HEIGHT - 1));
  assign pixel_out_valid = !fifo_empty;
  assign pixel_out       = fifo_empty ? '0 : fifo_dout;
  assign eol             = pixel_out_valid && last_col;
  assign eof             = pixel_out_valid && last_col && last_row;
  assign pause_upstream  = (fifo_count >= (AW+1)'(AF_LEVEL));
  assign frame_done      = (state_q == ST_DONE);
  assign state_dbg       = state_q;

  // Column/row position of the pixel currently at the FIFO head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (soft_clear) begin
      col_q <= '0;
      row_q <= '0;
    end else if (rd_en) begin
      if (last_col) begin
        col_q <= '0;
        row_q <= last_row ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Sticky drop flag: a result arrived with the FIFO full and no read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (soft_clear) begin
      overflow <= 1'b0;
    end else if (processed_data_valid && fifo_full && !rd_en) begin
      overflow <= 1'b1;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else if (soft_clear) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame FSM next state: the eof transfer ends a frame, DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (rd_en) state_d = (last_col && last_row) ? ST_DONE : ST_ACTIVE;
      ST_ACTIVE: if (rd_en && last_col && last_row) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_image_result_packer.sv
// Bench for image_result_packer with a 4x2 frame, SHIFT=3, 16-entry FIFO.
module tb_image_result_packer;
  import img_proc_pkg::*;

  localparam int W = 4;
  localparam int H = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  processed_data_in = '0;
  logic         processed_data_valid = 1'b0;
  logic         soft_clear = 1'b0;
  logic [7:0]   pixel_out;
  logic         pixel_out_valid;
  logic         pixel_out_ready = 1'b0;
  logic         eol;
  logic         eof;
  logic         pause_upstream;
  logic         overflow;
  logic         frame_done;
  frame_state_t state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];   // {pixel, eol, eof}
  int m_col = 0;
  int m_row = 0;
  bit expect_done = 1'b0;

  image_result_packer #(
    .OUT_WIDTH (W), .OUT_HEIGHT (H), .SHIFT (3), .FIFO_DEPTH (16), .AF_LEVEL (12)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .processed_data_in (processed_data_in),
    .processed_data_valid (processed_data_valid),
    .soft_clear (soft_clear),
    .pixel_out (pixel_out), .pixel_out_valid (pixel_out_valid),
    .pixel_out_ready (pixel_out_ready),
    .eol (eol), .eof (eof),
    .pause_upstream (pause_upstream), .overflow (overflow),
    .frame_done (frame_done), .state_dbg (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_col = 0;
    m_row = 0;
  endtask

  // Drive one input for one cycle; push its expected output unless it is lost.
  task automatic send(input logic [15:0] sum, input logic [7:0] pix, input bit push);
    processed_data_in    = sum;
    processed_data_valid = 1'b1;
    if (push) begin
      exp_q.push_back({pix, (m_col == W-1), (m_col == W-1) && (m_row == H-1)});
      if (m_col == W-1) begin
        m_col = 0;
        m_row = (m_row == H-1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
    @(posedge clk); #1;
    processed_data_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: compares every transfer against the scoreboard, and frame_done.
  always @(negedge clk) begin
    if (!rst_n) begin
      expect_done = 1'b0;
    end else begin
      if (expect_done || frame_done) check("frame_done", frame_done, expect_done);
      expect_done = 1'b0;
      if (pixel_out_valid && pixel_out_ready && !soft_clear) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", 1, 0);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          check("pixel_out", pixel_out, e[9:2]);
          check("eol", eol, e[1]);
          check("eof", eof, e[0]);
          if (e[0]) expect_done = 1'b1;
        end
      end
    end
  end

  initial begin
    // Reset state
    #12;
    check("rst_pixel", pixel_out, 0);
    check("rst_valid", pixel_out_valid, 0);
    check("rst_eol", eol, 0);
    check("rst_eof", eof, 0);
    check("rst_pause", pause_upstream, 0);
    check("rst_done", frame_done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_state", state_dbg, ST_IDLE);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Conversion and one full 4x2 frame with ready held high
    pixel_out_ready = 1'b1;
    send(16'h0010, 8'h02, 1);
    check("latency_valid", pixel_out_valid, 1);
    check("latency_pixel", pixel_out, 8'h02);
    send(16'hFFF8, 8'h00, 1);
    send(16'h0900, 8'hFF, 1);
    send(16'h07F8, 8'hFF, 1);
    send(16'h0800, 8'hFF, 1);
    send(16'h0008, 8'h01, 1);
    send(16'hFFFF, 8'h00, 1);
    send(16'h0007, 8'h00, 1);
    wait_drain();
    check("idle_after_frame", state_dbg, ST_IDLE);

    // Fill the FIFO with ready low
    pixel_out_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      send(16'(i * 16), 8'(2 * i), 1);
      if (i == 11) check("pause_at_11", pause_upstream, 0);
      if (i == 12) check("pause_at_12", pause_upstream, 1);
    end
    check("hold_pixel", pixel_out, 8'h02);
    check("hold_eol", eol, 0);
    check("full_no_ovf", overflow, 0);

    // Full FIFO, simultaneous write and read
    pixel_out_ready = 1'b1;
    send(16'h0398, 8'h73, 1);
    pixel_out_ready = 1'b0;
    check("wr_rd_full_ovf", overflow, 0);
    check("wr_rd_full_pause", pause_upstream, 1);
    check("wr_rd_full_head", pixel_out, 8'h04);

    // Full FIFO, no read: dropped
    send(16'h0100, 8'h20, 0);
    check("drop_ovf", overflow, 1);
    check("drop_head", pixel_out, 8'h04);
    pixel_out_ready = 1'b1;
    wait_drain();
    check("drained_valid", pixel_out_valid, 0);
    check("ovf_sticky", overflow, 1);

    // Soft clear with a valid input on the same cycle
    pixel_out_ready = 1'b0;
    send(16'h0050, 8'h0A, 0);
    send(16'h0058, 8'h0B, 0);
    processed_data_in    = 16'h0123;
    processed_data_valid = 1'b1;
    soft_clear           = 1'b1;
    model_reset();
    @(posedge clk); #1;
    processed_data_valid = 1'b0;
    soft_clear           = 1'b0;
    check("clr_valid", pixel_out_valid, 0);
    check("clr_state", state_dbg, ST_IDLE);
    check("clr_ovf", overflow, 0);
    check("clr_pause", pause_upstream, 0);
    pixel_out_ready = 1'b1;
    send(16'h8000, 8'h00, 1);
    send(16'h7FFF, 8'hFF, 1);
    send(16'h0011, 8'h02, 1);
    send(16'h07FF, 8'hFF, 1);
    wait_drain();

    // Reset mid-frame
    send(16'h0018, 8'h03, 1);
    send(16'h0020, 8'h04, 1);
    send(16'h0028, 8'h05, 1);
    send(16'h0030, 8'h06, 1);
    send(16'h0038, 8'h07, 1);
    wait_drain();
    pixel_out_ready = 1'b0;
    send(16'h0040, 8'h08, 0);
    send(16'h0048, 8'h09, 0);
    check("pre_rst_valid", pixel_out_valid, 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_valid", pixel_out_valid, 0);
    check("mid_rst_pixel", pixel_out, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_state", state_dbg, ST_IDLE);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", pixel_out_valid, 0);
    pixel_out_ready = 1'b1;
    send(16'h0050, 8'h0A, 1);
    send(16'h0058, 8'h0B, 1);
    send(16'h0060, 8'h0C, 1);
    send(16'h0068, 8'h0D, 1);
    wait_drain();
    check("final_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/image_result_packer.md
IMAGE_RESULT_PACKER -- requirements
Module: image_result_packer

Interface
REQ-001 Parameter OUT_WIDTH, default 511, output pixels per line.
REQ-002 Parameter OUT_HEIGHT, default 511, output lines per frame.
REQ-003 Parameter SHIFT, default 3, right-shift applied to the convolution sum before saturation.
REQ-004 Parameter FIFO_DEPTH, default 16, power of two, result buffer entries.
REQ-005 Parameter AF_LEVEL, default 12, fill level at which pause_upstream asserts.
REQ-006 Clocking: one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  single clock, rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 processed_data_in  in  16  signed convolution sum from the convolution core.
REQ-010 processed_data_valid  in  1  one result per high cycle; no backpressure is possible.
REQ-011 soft_clear  in  1  synchronous clear of FIFO, counters, FSM and the overflow flag.
REQ-012 pixel_out  out  8  saturated output pixel.
REQ-013 pixel_out_valid  out  1  pixel_out holds valid data.
REQ-014 pixel_out_ready  in  1  downstream accepts the pixel.
REQ-015 eol  out  1  qualifies the last pixel of a line; valid only while pixel_out_valid is high.
REQ-016 eof  out  1  qualifies the last pixel of a frame; valid only while pixel_out_valid is high.
REQ-017 pause_upstream  out  1  high while FIFO fill >= AF_LEVEL; the system uses it to throttle ready_for_data_in.
REQ-018 overflow  out  1  sticky flag, set when a result is dropped.
REQ-019 frame_done  out  1  one-cycle pulse after the eof pixel is accepted.

Function
REQ-020 Conversion SHALL arithmetic-right-shift the input by SHIFT, force negatives to 0, force values >255 to 255, and pass all other values through unchanged.
REQ-021 Conversion SHALL occur on FIFO write; the FIFO stores 8-bit pixels.
REQ-022 A transfer SHALL occur only on a cycle where pixel_out_valid and pixel_out_ready are both high.
REQ-023 Latency with the FIFO empty: input valid at cycle N SHALL give pixel_out_valid at cycle N+1.
REQ-024 pixel_out, eol and eof SHALL hold stable while pixel_out_valid is high and pixel_out_ready is low.
REQ-025 With the FIFO full, a simultaneous write and read SHALL accept the write, and the fill level SHALL be unchanged.
REQ-026 With the FIFO full and no read, an input result SHALL be dropped and overflow SHALL be set; the FIFO contents SHALL be unchanged.
REQ-027 With the FIFO empty, pixel_out_valid SHALL be low; ready at this point SHALL have no effect.
REQ-028 Column counter 0..OUT_WIDTH-1 and row counter 0..OUT_HEIGHT-1 SHALL advance on each output transfer.
REQ-029 The column counter SHALL wrap to 0 at OUT_WIDTH-1 and increment the row; the row SHALL wrap to 0 after the eof transfer.
REQ-030 eol SHALL equal (col==OUT_WIDTH-1); eof SHALL equal eol AND (row==OUT_HEIGHT-1).
REQ-031 FSM states SHALL be IDLE, ACTIVE and DONE.
REQ-032 FSM IDLE->ACTIVE on the first output transfer; ACTIVE->DONE on the eof transfer; DONE->IDLE after one cycle.
REQ-033 frame_done SHALL be high exactly in the DONE cycle.
REQ-034 An input arriving during DONE SHALL be buffered normally and belong to the next frame.
REQ-035 soft_clear SHALL take priority over a simultaneous write or read; the input on that cycle SHALL be discarded.
REQ-036 After soft_clear, the FSM SHALL be IDLE and the counters, FIFO and overflow flag SHALL be cleared.

Reset
REQ-037 rst_n low SHALL immediately clear FIFO pointers, fill level, counters and overflow, and SHALL set the FSM to IDLE.
REQ-038 During reset, pixel_out=0, pixel_out_valid=0, eol=0, eof=0, pause_upstream=0, frame_done=0.
REQ-039 Reset asserted mid-frame SHALL discard buffered pixels; the first pixel after release SHALL be col 0, row 0.
REQ-040 Reset deassertion is synchronised externally; the block SHALL perform no action on the first edge after release beyond normal operation.

Structure
REQ-041 Package img_proc_pkg SHALL hold the pixel width (8), sum width (16), the FSM state enum and default frame dimensions.
REQ-042 Sub-module result_fifo SHALL be a synchronous show-ahead FIFO (depth, data width, fill count, full/empty) instantiated once.
REQ-043 Counter widths SHALL be $clog2 of the frame dimensions.

Verification
REQ-044 Scenario: inputs 0x0010, 0xFFF8, 0x0900 with SHIFT=3 and ready=1 -> pixel_out 0x02, 0x00, 0xFF.
REQ-045 Scenario: OUT_WIDTH=4, OUT_HEIGHT=2, 8 inputs, ready=1 -> eol on pixels 3 and 7, eof on pixel 7, frame_done one cycle later.
REQ-046 Scenario: ready=0 and 16 inputs -> pause_upstream high after the 12th write; the 17th input sets overflow; a later drain returns the first 16 in order.
REQ-047 Scenario: FIFO full, input valid with ready=1 on the same cycle -> no overflow, fill stays 16.
REQ-048 Scenario: rst_n pulsed low after 5 of 8 pixels -> outputs zero, next frame starts at col 0, row 0, overflow=0.
REQ-049 Scenario: soft_clear on a cycle with valid input -> FIFO empty next cycle, input discarded, FSM IDLE.
